// File: rtl/systolic_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// systolic_seq_ctrl_if
//
// Bundles the signals exchanged between the tile sequencer, the tile
// scheduler, the systolic array edge feeders and the output writer.
//
//   start      scheduler -> sequencer   tile request
//   cfg_k      scheduler -> sequencer   reduction depth K
//   stall      feeders   -> sequencer   feeders not ready
//   out_ready  writer    -> sequencer   writer accepts current row
//   busy/done  sequencer -> scheduler   tile status, completion pulse
//   ce         sequencer -> array       global PE clock enable
//   load_diag  sequencer -> array       per anti-diagonal accumulator clear
//   a_row_*    sequencer -> A feeders   per-row enable and k index
//   b_col_*    sequencer -> B feeders   per-column enable and k index
//   out_valid/out_row  sequencer -> writer   drain handshake
//
// modport slave is the sequencer side; modport master is the environment.
// ---------------------------------------------------------------------------
interface systolic_seq_ctrl_if #(
    parameter int N  = 4,
    parameter int KW = 8
);
    logic                   start;
    logic [KW-1:0]          cfg_k;
    logic                   stall;
    logic                   busy;
    logic                   done;
    logic                   ce;
    logic [2*N-2:0]         load_diag;
    logic [N-1:0]           a_row_en;
    logic [N*KW-1:0]        a_row_k;
    logic [N-1:0]           b_col_en;
    logic [N*KW-1:0]        b_col_k;
    logic                   out_valid;
    logic [$clog2(N)-1:0]   out_row;
    logic                   out_ready;

    modport master (
        output start, cfg_k, stall, out_ready,
        input  busy, done, ce, load_diag, a_row_en, a_row_k,
               b_col_en, b_col_k, out_valid, out_row
    );

    modport slave (
        input  start, cfg_k, stall, out_ready,
        output busy, done, ce, load_diag, a_row_en, a_row_k,
               b_col_en, b_col_k, out_valid, out_row
    );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// ---------------------------------------------------------------------------
// systolic_seq_ctrl
//
// Sequencer for an N x N output-stationary systolic array of signed MAC PEs.
// One accepted start runs a whole C = A(NxK) * B(KxN) tile:
//   FEED  : feed counter t walks 0 .. K+2N-1 (held while stall), producing the
//           skewed A-row / B-column feed windows, the anti-diagonal clears and
//           the array clock enable.
//   DRAIN : accumulator rows 0 .. N-1 are offered to the output writer with a
//           valid/ready handshake; the array is frozen (ce = 0).
//   done  : one-cycle pulse in the first IDLE cycle after DRAIN.
//
// Ports: clk, rst_n (asynchronous, active-low) and the slave side of
// systolic_seq_ctrl_if (see that file for the signal list).
// ---------------------------------------------------------------------------
module systolic_seq_ctrl #(
    parameter int N  = 4,
    parameter int KW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    systolic_seq_ctrl_if.slave   bus
);
    localparam int RW = $clog2(N);
    // Enough headroom for K_max + 2N - 1 so t never wraps.
    localparam int TW = KW + $clog2(N) + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   t_q, t_d;
    logic [KW-1:0]   k_q, k_d;
    logic [RW-1:0]   row_q, row_d;
    logic            done_q, done_d;

    logic            in_feed;
    logic [TW-1:0]   t_last;
    logic [N-1:0]    win_en;
    logic [N*KW-1:0] win_k;
    logic [2*N-2:0]  diag_clr;

    assign in_feed = (state_q == ST_FEED);
    assign t_last  = TW'(k_q) + TW'(2 * N - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            k_q     <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            k_q     <= k_d;
            row_q   <= row_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        k_d     = k_q;
        row_d   = row_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    k_d     = bus.cfg_k;
                    t_d     = '0;
                    state_d = ST_FEED;
                end
            end
            ST_FEED: begin
                // A stalled cycle freezes t, hence every window and clear.
                if (!bus.stall) begin
                    if (t_q == t_last) begin
                        row_d   = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        t_d = t_q + TW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (bus.out_ready) begin
                    if (row_q == RW'(N - 1)) begin
                        row_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Row i (and column i) presents element k = t - i while 0 <= t - i < K.
    // The k index fits in KW bits whenever the window is open, so only the
    // low bits of t are needed for it.
    for (genvar gi = 0; gi < N; gi++) begin : g_win
        assign win_en[gi] = in_feed
                         && (t_q >= TW'(gi))
                         && (t_q <  TW'(k_q) + TW'(gi));
        assign win_k[gi*KW +: KW] = win_en[gi] ? (t_q[KW-1:0] - KW'(gi)) : '0;
    end

    // Diagonal d sees its first product added at t = d + 2; clear one cycle
    // earlier so the accumulator starts that add from zero.
    for (genvar gi = 0; gi < 2 * N - 1; gi++) begin : g_diag
        assign diag_clr[gi] = in_feed && (t_q == TW'(gi + 1));
    end

    assign bus.busy      = (state_q == ST_FEED) || (state_q == ST_DRAIN);
    assign bus.done      = done_q;
    assign bus.ce        = in_feed && !bus.stall;
    assign bus.load_diag = diag_clr;
    assign bus.a_row_en  = win_en;
    assign bus.a_row_k   = win_k;
    assign bus.b_col_en  = win_en;
    assign bus.b_col_k   = win_k;
    assign bus.out_valid = (state_q == ST_DRAIN);
    assign bus.out_row   = row_q;
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_systolic_seq_ctrl
//
// Drives tiles through the sequencer, with a behavioural N x N MAC array and
// edge feeders attached to its outputs. Each cycle the controller outputs are
// compared with the feed-window / clear / enable rules evaluated from the
// bench's own count of unstalled FEED cycles, and every drained row is
// compared with a golden matrix product.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_systolic_seq_ctrl;
    localparam int N  = 4;
    localparam int KW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    systolic_seq_ctrl_if #(.N(N), .KW(KW)) bus ();

    systolic_seq_ctrl #(.N(N), .KW(KW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input longint obs, input longint exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // ---------------- operand matrices and golden result -----------------
    logic signed [7:0] a_mat [N][256];
    logic signed [7:0] b_mat [256][N];
    longint            c_gold [N][N];

    // ---------------- behavioural array + feeders --------------------------
    logic signed [7:0]  feed_a [N];
    logic signed [7:0]  feed_b [N];
    logic signed [7:0]  a_in   [N][N];
    logic signed [7:0]  b_in   [N][N];
    logic signed [7:0]  a_pipe [N][N];
    logic signed [7:0]  b_pipe [N][N];
    logic signed [15:0] p1     [N][N];
    logic signed [15:0] p2     [N][N];
    logic signed [31:0] acc    [N][N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            feed_a[i] = 8'sd0;
            feed_b[i] = 8'sd0;
            if (bus.a_row_en[i]) feed_a[i] = a_mat[i][bus.a_row_k[i*KW +: KW]];
            if (bus.b_col_en[i]) feed_b[i] = b_mat[bus.b_col_k[i*KW +: KW]][i];
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j == 0) a_in[i][j] = feed_a[i];
                else        a_in[i][j] = a_pipe[i][j-1];
                if (i == 0) b_in[i][j] = feed_b[j];
                else        b_in[i][j] = b_pipe[i-1][j];
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_pipe[i][j] <= '0;
                    b_pipe[i][j] <= '0;
                    p1[i][j]     <= '0;
                    p2[i][j]     <= '0;
                    acc[i][j]    <= '0;
                end
            end
        end else if (bus.ce) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_pipe[i][j] <= a_in[i][j];
                    b_pipe[i][j] <= b_in[i][j];
                    p1[i][j]     <= a_in[i][j] * b_in[i][j];
                    p2[i][j]     <= p1[i][j];
                    acc[i][j]    <= bus.load_diag[i+j] ? 32'sd0 : acc[i][j] + p2[i][j];
                end
            end
        end
    end

    // Expected FEED outputs after t unstalled cycles of a depth-k tile.
    function automatic void exp_win(input int t, input int k,
                                    output logic [N-1:0] en,
                                    output logic [N*KW-1:0] kv,
                                    output logic [2*N-2:0] ld);
        en = '0;
        kv = '0;
        ld = '0;
        for (int i = 0; i < N; i++) begin
            if (t >= i && t - i < k) begin
                en[i] = 1'b1;
                kv[i*KW +: KW] = KW'(t - i);
            end
        end
        for (int d = 0; d < 2 * N - 1; d++) ld[d] = (t == d + 1);
    endfunction

    task automatic check_idle_outputs(input string pfx);
        check_val({pfx, "_busy"},      bus.busy,      0);
        check_val({pfx, "_done"},      bus.done,      0);
        check_val({pfx, "_ce"},        bus.ce,        0);
        check_val({pfx, "_load_diag"}, bus.load_diag, 0);
        check_val({pfx, "_a_row_en"},  bus.a_row_en,  0);
        check_val({pfx, "_a_row_k"},   bus.a_row_k,   0);
        check_val({pfx, "_b_col_en"},  bus.b_col_en,  0);
        check_val({pfx, "_b_col_k"},   bus.b_col_k,   0);
        check_val({pfx, "_out_valid"}, bus.out_valid, 0);
        check_val({pfx, "_out_row"},   bus.out_row,   0);
    endtask

    task automatic run_tile(input int k, input int st_at, input int st_len,
                            input int hold_row, input int hold_len, input bit rnd);
        int t, row, n_st, n_hold, hold;
        logic stall_v, rdy;
        logic [N-1:0]    e_en;
        logic [N*KW-1:0] e_k;
        logic [2*N-2:0]  e_ld;

        for (int i = 0; i < N; i++) begin
            for (int kk = 0; kk < k; kk++) begin
                a_mat[i][kk] = 8'($urandom);
                b_mat[kk][i] = 8'($urandom);
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                c_gold[i][j] = 0;
                for (int kk = 0; kk < k; kk++)
                    c_gold[i][j] += longint'(a_mat[i][kk]) * longint'(b_mat[kk][j]);
            end
        end

        @(negedge clk);
        bus.start     = 1'b1;
        bus.cfg_k     = KW'(k);
        bus.stall     = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.out_ready = 1'b1;

        t = 0; n_st = 0; n_hold = 0; hold = 0;
        while (t < k + 2 * N) begin
            @(negedge clk);
            bus.start = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.cfg_k = KW'($urandom);
            if (rnd) stall_v = ($urandom_range(0, 3) == 0);
            else     stall_v = (t == st_at) && (n_st < st_len);
            bus.stall = stall_v;
            #1;
            exp_win(t, k, e_en, e_k, e_ld);
            check_val("feed_busy",      bus.busy,      1);
            check_val("feed_done",      bus.done,      0);
            check_val("feed_out_valid", bus.out_valid, 0);
            check_val("feed_ce",        bus.ce,        !stall_v);
            check_val("feed_a_row_en",  bus.a_row_en,  e_en);
            check_val("feed_b_col_en",  bus.b_col_en,  e_en);
            check_val("feed_a_row_k",   bus.a_row_k,   e_k);
            check_val("feed_b_col_k",   bus.b_col_k,   e_k);
            check_val("feed_load_diag", bus.load_diag, e_ld);
            if (stall_v) n_st++;
            else         t++;
        end

        row = 0;
        while (row < N) begin
            @(negedge clk);
            bus.start = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.stall = 1'($urandom_range(0, 1));
            if (rnd) rdy = ($urandom_range(0, 2) != 0);
            else     rdy = !((row == hold_row) && (hold < hold_len));
            bus.out_ready = rdy;
            #1;
            check_val("drain_busy",      bus.busy,      1);
            check_val("drain_out_valid", bus.out_valid, 1);
            check_val("drain_done",      bus.done,      0);
            check_val("drain_ce",        bus.ce,        0);
            check_val("drain_out_row",   bus.out_row,   row);
            check_val("drain_load_diag", bus.load_diag, 0);
            check_val("drain_a_row_en",  bus.a_row_en,  0);
            check_val("drain_b_col_en",  bus.b_col_en,  0);
            if (rdy) begin
                for (int j = 0; j < N; j++)
                    check_val($sformatf("c_%0d_%0d", row, j), acc[row][j], c_gold[row][j]);
                row++;
            end else begin
                hold++;
                n_hold++;
            end
        end

        @(negedge clk);
        bus.start     = 1'b0;
        bus.stall     = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check_val("done_pulse",     bus.done,      1);
        check_val("done_busy",      bus.busy,      0);
        check_val("done_out_valid", bus.out_valid, 0);
        check_val("done_ce",        bus.ce,        0);
        @(negedge clk);
        #1;
        check_val("post_done", bus.done, 0);
        check_val("post_busy", bus.busy, 0);
        $display("tile K=%0d stall_cycles=%0d hold_cycles=%0d rnd=%0d complete",
                 k, n_st, n_hold, rnd);
    endtask

    task automatic reset_midtile();
        @(negedge clk);
        bus.start = 1'b1;
        bus.cfg_k = KW'(6);
        bus.stall = 1'b0;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        #1;
        check_val("rst_pre_busy",      bus.busy,      1);
        check_val("rst_pre_load_diag", bus.load_diag, 8);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_async");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check_val("rst_hold_done", bus.done, 0);
            check_val("rst_hold_busy", bus.busy, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rst_release_done", bus.done, 0);
        $display("reset asserted at FEED t=4, tile discarded");
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.cfg_k     = '0;
        bus.stall     = 1'b0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;

        run_tile(3, -1, 0, -1, 0, 1'b0);   // baseline
        run_tile(3,  5, 2, -1, 0, 1'b0);   // two-cycle stall at t = 5
        run_tile(0, -1, 0, -1, 0, 1'b0);   // empty reduction
        run_tile(5, -1, 0,  1, 3, 1'b0);   // writer backpressure on row 1
        reset_midtile();
        run_tile(4, -1, 0, -1, 0, 1'b0);   // fresh tile after reset
        run_tile(12, -1, 0, -1, 0, 1'b0);
        for (int r = 0; r < 6; r++)
            run_tile(int'($urandom_range(0, 12)), -1, 0, -1, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
